// File: rtl/regfile_sb_pkg.sv
// Shared defaults and bank-select encoding for the scoreboarded integer/FP register file.
package regfile_sb_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;

    typedef enum logic {
        BANK_INT = 1'b0,
        BANK_FP  = 1'b1
    } bank_e;

    // Upper register of an aligned pair; stays inside AW bits so it cannot wrap.
    function automatic logic [15:0] pair_hi(input logic [15:0] addr);
        return addr | 16'd1;
    endfunction

endpackage

// File: rtl/regfile_sb_bank.sv
// One register bank: data array, busy vector, and combinational reads with same-cycle writeback bypass.
module regfile_bank
    import regfile_sb_pkg::*;
#(
    parameter int  DATA_W   = DEF_DATA_W,
    parameter int  NUM_REGS = DEF_NUM_REGS,
    parameter int  NUM_RD   = DEF_NUM_RD,
    parameter bit  IS_INT   = 1'b0,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             iss_en,
    input  logic                             iss_dbl,
    input  logic [AW-1:0]                    iss_addr,
    input  logic                             wb_en,
    input  logic                             wb_dbl,
    input  logic [AW-1:0]                    wb_addr,
    input  logic [DATA_W-1:0]                wb_data_lo,
    input  logic [DATA_W-1:0]                wb_data_hi,
    input  logic [NUM_RD-1:0][AW-1:0]        rd_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]    rd_data_lo,
    output logic [NUM_RD-1:0][DATA_W-1:0]    rd_data_hi,
    output logic [NUM_RD-1:0]                rd_busy,
    output logic [NUM_REGS-1:0]              busy_q,
    output logic [NUM_REGS-1:0]              busy_d
);

    logic [DATA_W-1:0]               mem [NUM_REGS];
    logic [NUM_REGS-1:0]             we;
    logic [NUM_REGS-1:0]             set;
    logic [NUM_REGS-1:0][DATA_W-1:0] wd;
    logic [AW-1:0]                   wb_hi;
    logic [AW-1:0]                   iss_hi;

    assign wb_hi  = AW'(pair_hi(16'(wb_addr)));
    assign iss_hi = AW'(pair_hi(16'(iss_addr)));

    // Per-register write enable/data is shared by the array update and the read bypass.
    always_comb begin
        we  = '0;
        set = '0;
        wd  = '0;
        if (wb_en) begin
            we[wb_addr] = 1'b1;
            wd[wb_addr] = wb_data_lo;
            if (wb_dbl) begin
                we[wb_hi] = 1'b1;
                wd[wb_hi] = wb_data_hi;
            end
        end
        if (iss_en) begin
            set[iss_addr] = 1'b1;
            if (iss_dbl)
                set[iss_hi] = 1'b1;
        end
        if (IS_INT) begin
            we[0]  = 1'b0;
            set[0] = 1'b0;
        end
    end

    // A fresh reservation wins over a writeback that lands on the same register.
    assign busy_d = (busy_q & ~we) | set;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                mem[i] <= '0;
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < NUM_REGS; i++)
                if (we[i])
                    mem[i] <= wd[i];
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] lo_a;
        logic [AW-1:0] hi_a;
        assign lo_a          = rd_addr[p];
        assign hi_a          = AW'(pair_hi(16'(lo_a)));
        assign rd_data_lo[p] = we[lo_a] ? wd[lo_a] : mem[lo_a];
        assign rd_data_hi[p] = IS_INT ? '0 : (we[hi_a] ? wd[hi_a] : mem[hi_a]);
        assign rd_busy[p]    = busy_q[lo_a] | (!IS_INT && busy_q[hi_a]);
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer + FP register file with per-register scoreboard, double-precision pair access and sticky alignment error.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int  DATA_W   = DEF_DATA_W,
    parameter int  NUM_REGS = DEF_NUM_REGS,
    parameter int  NUM_RD   = DEF_NUM_RD,
    localparam int AW       = $clog2(NUM_REGS),
    localparam int CW       = $clog2(2*NUM_REGS) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_RD-1:0][AW-1:0]        rd_addr,
    input  logic [NUM_RD-1:0]                rd_fp,
    output logic [NUM_RD-1:0][DATA_W-1:0]    rd_data_lo,
    output logic [NUM_RD-1:0][DATA_W-1:0]    rd_data_hi,
    output logic [NUM_RD-1:0]                rd_busy,
    input  logic                             iss_valid,
    input  logic                             iss_fp,
    input  logic                             iss_dbl,
    input  logic [AW-1:0]                    iss_addr,
    output logic                             iss_ready,
    input  logic                             wb_valid,
    input  logic                             wb_fp,
    input  logic                             wb_dbl,
    input  logic [AW-1:0]                    wb_addr,
    input  logic [DATA_W-1:0]                wb_data_lo,
    input  logic [DATA_W-1:0]                wb_data_hi,
    output logic [CW-1:0]                    pending_cnt,
    output logic                             align_err
);

    logic                          iss_bad, wb_bad, wb_ok, iss_hit;
    logic [AW-1:0]                 iss_hi;
    logic [NUM_REGS-1:0]           tgt_busy;
    logic [NUM_REGS-1:0]           i_busy_q, i_busy_d, f_busy_q, f_busy_d;
    logic [NUM_RD-1:0][DATA_W-1:0] i_lo, i_hi, f_lo, f_hi;
    logic [NUM_RD-1:0]             i_rbusy, f_rbusy;
    logic [CW-1:0]                 cnt_d;

    // Doubles must be FP and even; anything else is dropped and flagged.
    assign iss_bad   = iss_dbl && (iss_fp != BANK_FP || iss_addr[0]);
    assign wb_bad    = wb_dbl  && (wb_fp  != BANK_FP || wb_addr[0]);
    assign wb_ok     = wb_valid && !wb_bad;
    assign iss_hi    = AW'(pair_hi(16'(iss_addr)));
    assign tgt_busy  = (iss_fp == BANK_FP) ? f_busy_q : i_busy_q;
    assign iss_hit   = tgt_busy[iss_addr] | (iss_dbl & tgt_busy[iss_hi]);
    assign iss_ready = iss_valid && !iss_bad && !iss_hit;

    regfile_bank #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .IS_INT(1'b1)
    ) u_int (
        .clk        (clk),
        .rst        (rst),
        .iss_en     (iss_ready && iss_fp == BANK_INT),
        .iss_dbl    (iss_dbl),
        .iss_addr   (iss_addr),
        .wb_en      (wb_ok && wb_fp == BANK_INT),
        .wb_dbl     (wb_dbl),
        .wb_addr    (wb_addr),
        .wb_data_lo (wb_data_lo),
        .wb_data_hi (wb_data_hi),
        .rd_addr    (rd_addr),
        .rd_data_lo (i_lo),
        .rd_data_hi (i_hi),
        .rd_busy    (i_rbusy),
        .busy_q     (i_busy_q),
        .busy_d     (i_busy_d)
    );

    regfile_bank #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .IS_INT(1'b0)
    ) u_fp (
        .clk        (clk),
        .rst        (rst),
        .iss_en     (iss_ready && iss_fp == BANK_FP),
        .iss_dbl    (iss_dbl),
        .iss_addr   (iss_addr),
        .wb_en      (wb_ok && wb_fp == BANK_FP),
        .wb_dbl     (wb_dbl),
        .wb_addr    (wb_addr),
        .wb_data_lo (wb_data_lo),
        .wb_data_hi (wb_data_hi),
        .rd_addr    (rd_addr),
        .rd_data_lo (f_lo),
        .rd_data_hi (f_hi),
        .rd_busy    (f_rbusy),
        .busy_q     (f_busy_q),
        .busy_d     (f_busy_d)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_mux
        assign rd_data_lo[p] = rd_fp[p] ? f_lo[p]    : i_lo[p];
        assign rd_data_hi[p] = rd_fp[p] ? f_hi[p]    : i_hi[p];
        assign rd_busy[p]    = rd_fp[p] ? f_rbusy[p] : i_rbusy[p];
    end

    // Count the next-state busy bits so pending_cnt moves on the same edge as the scoreboard.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d = cnt_d + {{(CW-1){1'b0}}, i_busy_d[i]};
            cnt_d = cnt_d + {{(CW-1){1'b0}}, f_busy_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_cnt <= '0;
            align_err   <= 1'b0;
        end else begin
            pending_cnt <= cnt_d;
            align_err   <= align_err | (iss_valid && iss_bad) | (wb_valid && wb_bad);
        end
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning registers per bank; it is a power of two, AW = log2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2, meaning independent read ports.
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports listed below.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: rst  in  1  synchronous active-high reset.
REQ-007 Port: rd_addr  in  NUM_RD*AW  per-port read address.
REQ-008 Port: rd_fp  in  NUM_RD  per-port bank select: 1 selects FP, 0 selects integer.
REQ-009 Port: rd_data_lo  out  NUM_RD*DATA_W  value of reg[addr].
REQ-010 Port: rd_data_hi  out  NUM_RD*DATA_W  value of FP reg[addr|1]; 0 for the integer bank.
REQ-011 Port: rd_busy  out  NUM_RD  scoreboard busy bit of the addressed register (or pair).
REQ-012 Port: iss_valid / iss_fp / iss_dbl / iss_addr  in  1/1/1/AW  issue reservation of a destination.
REQ-013 Port: iss_ready  out  1  reservation accepted this cycle.
REQ-014 Port: wb_valid / wb_fp / wb_dbl / wb_addr  in  1/1/1/AW  writeback request.
REQ-015 Port: wb_data_lo / wb_data_hi  in  DATA_W each  writeback data (hi is used only for a double write).
REQ-016 Port: pending_cnt  out  log2(2*NUM_REGS)+1  number of busy bits set.
REQ-017 Port: align_err  out  1  sticky flag for a misaligned double request.

Function
REQ-018 SHALL hold two banks, integer and FP, each NUM_REGS x DATA_W, plus one busy bit per register per bank.
REQ-019 Integer reg 0 SHALL read 0, ignore writes, and never become busy.
REQ-020 Reads SHALL be combinational.
REQ-021 A writeback to the same bank and address in the same cycle SHALL be bypassed to rd_data_lo/hi, giving 0-cycle write-to-read latency.
REQ-022 A writeback SHALL update the array at the next rising edge and clear the target busy bit(s); a double writeback writes and clears addr and addr+1.
REQ-023 A double request (iss or wb) SHALL require an even addr and fp=1; otherwise it SHALL be ignored and SHALL set align_err.
REQ-024 An integer double request SHALL be treated as misaligned.
REQ-025 iss_ready SHALL be 1 iff iss_valid is 1, the request is well-formed, and no target busy bit is set in the current (registered) state.
REQ-026 On acceptance, the target busy bit(s) SHALL be set at the next edge.
REQ-027 An issue targeting integer reg 0 SHALL be accepted and SHALL NOT set busy.
REQ-028 Simultaneous issue and writeback to the same busy register: the writeback completes and clears busy; the issue is refused (iss_ready=0) that cycle.
REQ-029 Simultaneous issue and writeback to different registers SHALL both take effect.
REQ-030 A writeback to a non-busy register SHALL still write data.
REQ-031 rd_busy SHALL reflect the registered busy state, not the bypassed state.
REQ-032 For a double-aligned FP read, rd_busy SHALL be the OR of the pair's busy bits; for an odd FP addr, rd_data_hi SHALL equal rd_data_lo's own register (addr|1 = addr).
REQ-033 pending_cnt SHALL equal the popcount of all busy bits, registered and updated at the same edge as the busy bits.
REQ-034 Address arithmetic SHALL stay within AW bits; addr|1 never wraps.

Reset
REQ-035 On rst=1 at a rising edge, all registers, busy bits, pending_cnt and align_err SHALL clear to 0.
REQ-036 Reset SHALL take priority over a simultaneous issue or writeback.
REQ-037 During reset, iss_ready SHALL still evaluate combinationally, but no state change from it SHALL take effect.
REQ-038 Reset mid-operation SHALL discard all outstanding reservations.

Structure
REQ-039 A shared package SHALL hold the default DATA_W/NUM_REGS/NUM_RD values and the bank-select encoding (BANK_INT=0, BANK_FP=1).
REQ-040 One sub-module, regfile_bank, SHALL implement a single bank (array, busy vector, bypass read) and be instantiated twice.
REQ-041 The popcount and align_err logic SHALL reside in regfile_sb.

Verification
REQ-042 Reset, then read all addrs on both banks -> data 0, busy 0, pending_cnt 0.
REQ-043 Issue FP dbl addr 4 -> iss_ready=1, next cycle rd_busy(f4)=1, pending_cnt=2; re-issue f5 -> iss_ready=0.
REQ-044 WB FP dbl addr 4, lo=0x3FF00000, hi=0x00000000 while reading f4 -> same-cycle rd_data_lo=0x3FF00000, hi=0; next cycle busy cleared, pending_cnt=0.
REQ-045 Integer write r0=0xDEADBEEF, then read r0 -> 0; issue r0 -> iss_ready=1, pending_cnt unchanged.
REQ-046 FP dbl issue at odd addr 7 -> iss_ready=0, align_err=1 (sticky until rst), busy unchanged.
REQ-047 Issue r3 and WB r3 in the same cycle with r3 busy -> r3 written, busy cleared, issue refused; retry next cycle -> accepted.
